// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package writeback_arbiter_pkg;

   // Default writeback data width.
   localparam int SIZE_DEFAULT = 32;

   // Register-number width and the hard-wired zero register.
   localparam int               REG_W    = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // Starvation FSM. IDLE means the queue is empty, QUEUED means it holds
   // entries with no forced drain pending, and DRAIN is the one-cycle Stall.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      QUEUED = 2'd1,
      DRAIN  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Memory-source writeback queue. Each entry holds a destination register and
// its data. Every entry's valid bit and register number are exported so that
// the parent can run a hazard lookup across all outstanding writes.
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int SIZE  = SIZE_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push,
   input  logic [REG_W-1:0]            push_reg,
   input  logic [SIZE-1:0]             push_data,
   input  logic                        pop,
   output logic [REG_W-1:0]            head_reg,
   output logic [SIZE-1:0]             head_data,
   output logic [$clog2(DEPTH):0]      count,
   output logic [DEPTH-1:0]            entry_valid,
   output logic [DEPTH-1:0][REG_W-1:0] entry_reg
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [PTR_W:0]              count_q;
   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0][REG_W-1:0] reg_mem;
   logic [SIZE-1:0]             data_mem [DEPTH];

   // Pointer, occupancy and per-entry valid bookkeeping; the pointers wrap
   // naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         // NOTE: non-blocking assignments here, so every flop in the block
         // reads values from before the clock edge.
         if (pop) begin
            rd_ptr          <= rd_ptr + PTR_W'(1);
            valid_q[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr          <= wr_ptr + PTR_W'(1);
            valid_q[wr_ptr] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage, written only on push.
   always_ff @(posedge clock) begin
      // NOTE: the storage has no reset. valid_q and the pointers decide which
      // entries are live, so clearing the contents would add nothing.
      if (push) begin
         reg_mem[wr_ptr]  <= push_reg;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign head_reg    = reg_mem[rd_ptr];
   assign head_data   = data_mem[rd_ptr];
   assign count       = count_q;
   assign entry_valid = valid_q;
   assign entry_reg   = reg_mem;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter. The pipeline (ALU) source has priority
// over a queue of memory/multicycle results. A starvation counter forces a
// one-cycle Stall after STARVE consecutive ALU wins while the queue waits.
// The selected write appears on registered outputs one cycle later.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int SIZE   = SIZE_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int STARVE = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             AluValid,
   input  logic [REG_W-1:0] AluReg,
   input  logic [SIZE-1:0]  AluData,
   input  logic             MemValid,
   input  logic [REG_W-1:0] MemReg,
   input  logic [SIZE-1:0]  MemData,
   output logic             MemReady,
   output logic             Stall,
   output logic [REG_W-1:0] WriteReg,
   output logic [SIZE-1:0]  WriteData,
   output logic             RegWrite,
   input  logic [REG_W-1:0] ChkReg,
   output logic             ChkPending
);

   localparam int                CNT_W       = $clog2(DEPTH) + 1;
   localparam int                STARVE_W    = $clog2(STARVE + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE - 1);

   logic [REG_W-1:0]            head_reg;
   logic [SIZE-1:0]             head_data;
   logic [CNT_W-1:0]            fifo_count;
   logic [DEPTH-1:0]            entry_valid;
   logic [DEPTH-1:0][REG_W-1:0] entry_reg;

   logic                        push;
   logic                        pop;
   logic                        q_nonempty;
   logic                        sel_alu;
   logic                        sel_valid;
   logic [REG_W-1:0]            sel_reg;
   logic [SIZE-1:0]             sel_data;
   logic [CNT_W-1:0]            count_after;

   logic [STARVE_W-1:0]         starve_q;
   logic [STARVE_W-1:0]         starve_d;
   logic                        starve_hit;

   wb_state_t                   state_q;
   wb_state_t                   state_d;

   wb_fifo #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_reg    (MemReg),
      .push_data   (MemData),
      .pop         (pop),
      .head_reg    (head_reg),
      .head_data   (head_data),
      .count       (fifo_count),
      .entry_valid (entry_valid),
      .entry_reg   (entry_reg)
   );

   // A full queue refuses new entries, even in a cycle where it also drains.
   assign MemReady   = (fifo_count < DEPTH_C);
   assign push       = MemValid && MemReady;
   assign q_nonempty = (fifo_count != '0);
   assign Stall      = (state_q == DRAIN);

   // Source selection: the ALU wins unless stalled, otherwise the queue head.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      sel_alu   = AluValid && !Stall;
      pop       = !sel_alu && q_nonempty;
      sel_valid = sel_alu || pop;
      sel_reg   = head_reg;
      sel_data  = head_data;
      if (sel_alu) begin
         sel_reg  = AluReg;
         sel_data = AluData;
      end
   end

   // Starvation counting: counts ALU wins while the queue waits; the
   // STARVE-th such win schedules a drain.
   always_comb begin
      starve_d   = '0;
      starve_hit = 1'b0;
      if (sel_alu && q_nonempty) begin
         starve_d   = starve_q + STARVE_W'(1);
         starve_hit = (starve_q == STARVE_LAST);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end

   // Next state: the queue occupancy after this cycle picks IDLE or QUEUED,
   // unless a drain has just been earned.
   always_comb begin
      state_d     = state_q;
      count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
      unique case (state_q)
         IDLE, QUEUED: begin
            if (starve_hit)              state_d = DRAIN;
            else if (count_after != '0)  state_d = QUEUED;
            else                         state_d = IDLE;
         end
         DRAIN: begin
            state_d = (count_after != '0) ? QUEUED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Output register. A write to register zero is consumed but produces no
   // write enable.
   always_ff @(posedge clock) begin
      if (reset) begin
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else begin
         RegWrite <= sel_valid && (sel_reg != REG_ZERO);
         if (sel_valid && (sel_reg != REG_ZERO)) begin
            WriteReg  <= sel_reg;
            WriteData <= sel_data;
         end
      end
   end

   // Hazard lookup across the live queue entries and the write in flight.
   always_comb begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_reg[i] == ChkReg)) hit = 1'b1;
      end
      if (RegWrite && (WriteReg == ChkReg)) hit = 1'b1;
      ChkPending = hit && (ChkReg != REG_ZERO);
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by
// a randomized phase. All of it is checked against a queue-based reference
// model of the arbitration rules.
module tb_writeback_arbiter;

   localparam int SIZE   = 32;
   localparam int DEPTH  = 4;
   localparam int STARVE = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        AluValid, MemValid;
   logic [4:0]  AluReg, MemReg, ChkReg;
   logic [31:0] AluData, MemData;
   logic        MemReady, Stall, RegWrite, ChkPending;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   // Reference model state.
   ent_t        q[$];
   int          streak;
   bit          m_stall;
   bit          m_rw;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata;

   writeback_arbiter #(
      .SIZE   (SIZE),
      .DEPTH  (DEPTH),
      .STARVE (STARVE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .AluValid   (AluValid),
      .AluReg     (AluReg),
      .AluData    (AluData),
      .MemValid   (MemValid),
      .MemReg     (MemReg),
      .MemData    (MemData),
      .MemReady   (MemReady),
      .Stall      (Stall),
      .WriteReg   (WriteReg),
      .WriteData  (WriteData),
      .RegWrite   (RegWrite),
      .ChkReg     (ChkReg),
      .ChkPending (ChkPending)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic model_clear();
      q.delete();
      streak  = 0;
      m_stall = 0;
      m_rw    = 0;
      m_wreg  = '0;
      m_wdata = '0;
   endtask

   // One clock cycle: compare the DUT against the model for the current
   // cycle, advance the model by the arbitration rules, then clock.
   task automatic tick();
      bit          rdy, pend, was_ne, alu_win, sel;
      logic [4:0]  sr;
      logic [31:0] sd;
      ent_t        e;
      #1;
      rdy  = (q.size() < DEPTH);
      pend = 0;
      if (ChkReg != 0) begin
         foreach (q[i]) if (q[i].r == ChkReg) pend = 1;
         if (m_rw && m_wreg == ChkReg) pend = 1;
      end
      check("stall", Stall, m_stall);
      check("mem_ready", MemReady, rdy);
      check("reg_write", RegWrite, m_rw);
      if (m_rw) begin
         check("write_reg", WriteReg, m_wreg);
         check("write_data", WriteData, m_wdata);
      end
      check("chk_pending", ChkPending, pend);
      if (reset) begin
         model_clear();
      end else begin
         was_ne  = (q.size() != 0);
         alu_win = AluValid && !m_stall;
         sel     = 0;
         sr      = '0;
         sd      = '0;
         if (alu_win) begin
            sel = 1; sr = AluReg; sd = AluData;
         end else if (was_ne) begin
            e = q.pop_front();
            sel = 1; sr = e.r; sd = e.d;
         end
         if (MemValid && rdy) q.push_back(ent_t'{MemReg, MemData});
         streak  = (alu_win && was_ne) ? streak + 1 : 0;
         m_stall = (streak == STARVE);
         m_rw    = sel && (sr != 0);
         if (m_rw) begin
            m_wreg  = sr;
            m_wdata = sd;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      AluValid = 0;
      MemValid = 0;
      repeat (n) tick();
   endtask

   initial begin
      reset = 1; AluValid = 0; AluReg = 0; AluData = 0;
      MemValid = 0; MemReg = 0; MemData = 0; ChkReg = 0;

      // Reset state.
      repeat (2) @(posedge clock);
      #1;
      check("rst_regwrite", RegWrite, 1'b0);
      check("rst_writereg", WriteReg, 5'd0);
      check("rst_writedata", WriteData, 32'd0);
      check("rst_stall", Stall, 1'b0);
      check("rst_memready", MemReady, 1'b1);
      check("rst_chkpending", ChkPending, 1'b0);
      model_clear();
      reset = 0;

      // ALU-only write.
      AluValid = 1; AluReg = 5'd17; AluData = 32'h4;
      tick();
      check("alu_rw", RegWrite, 1'b1);
      check("alu_reg", WriteReg, 5'd17);
      check("alu_data", WriteData, 32'h4);

      // Register zero is consumed without a write.
      AluReg = 5'd0; AluData = 32'hFFFF_FFFF; ChkReg = 5'd0;
      tick();
      check("zero_rw", RegWrite, 1'b0);
      check("zero_chk", ChkPending, 1'b0);
      idle(2);

      // Fill the queue while the ALU holds priority, then drain it in order.
      AluValid = 1; AluReg = 5'd9; AluData = 32'h99;
      for (int i = 1; i <= 4; i++) begin
         MemValid = 1; MemReg = 5'(i); MemData = 32'h100 + i;
         tick();
      end
      MemValid = 0; AluValid = 0;
      check("full_ready", MemReady, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 1) check("ready_after_drain", MemReady, 1'b1);
         check("drain_rw", RegWrite, 1'b1);
         check("drain_order", WriteReg, 5'(i));
      end
      idle(2);

      // Starvation: one queued entry under continuous ALU traffic.
      AluValid = 1; AluReg = 5'd8; AluData = 32'hA0;
      MemValid = 1; MemReg = 5'd18; MemData = 32'h1;
      for (int k = 0; k < 13; k++) begin
         if (k >= 1) MemValid = 0;
         if (k >= 1 && k != 10) begin
            AluReg  = 5'(8 + k);
            AluData = 32'hA0 + k;
         end
         check("starve_stall", Stall, (k == 9));
         if (k == 10) begin
            check("starve_q_rw", RegWrite, 1'b1);
            check("starve_q_reg", WriteReg, 5'd18);
            check("starve_q_data", WriteData, 32'h1);
         end
         if (k == 11) check("starve_alu_after", WriteReg, 5'd17);
         tick();
      end
      idle(2);

      // Hazard lookup on a queued write to register 5.
      ChkReg = 5'd5;
      AluValid = 1; AluReg = 5'd9; AluData = 32'h9;
      MemValid = 1; MemReg = 5'd5; MemData = 32'h55;
      tick();
      MemValid = 0;
      check("haz_queued0", ChkPending, 1'b1);
      tick();
      check("haz_queued1", ChkPending, 1'b1);
      AluValid = 0;
      tick();
      check("haz_inflight_rw", RegWrite, 1'b1);
      check("haz_inflight", ChkPending, 1'b1);
      tick();
      check("haz_clear", ChkPending, 1'b0);
      idle(2);

      // Reset with three queued entries discards them.
      AluValid = 1; AluReg = 5'd9;
      for (int i = 0; i < 3; i++) begin
         MemValid = 1; MemReg = 5'(11 + i); MemData = 32'h200 + i;
         tick();
      end
      MemValid = 0; AluValid = 0; ChkReg = 5'd12;
      reset = 1;
      tick();
      reset = 0;
      check("rst_mid_ready", MemReady, 1'b1);
      check("rst_mid_chk", ChkPending, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_mid_rw", RegWrite, 1'b0);
      end

      // Randomized traffic; the ALU request is held while stalled.
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 149) == 0);
         if (!m_stall) begin
            AluValid = ($urandom_range(0, 9) < 6);
            AluReg   = 5'($urandom_range(0, 7));
            AluData  = $urandom;
         end
         MemValid = ($urandom_range(0, 9) < 5);
         MemReg   = 5'($urandom_range(0, 7));
         MemData  = $urandom;
         ChkReg   = 5'($urandom_range(0, 7));
         tick();
      end
      reset = 0;
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
